// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control sequencer. Accepts one instruction per
// handshake, walks it through DECODE/EXEC/MEM/WB, holds the decoded control
// word for the whole instruction and bounds the memory wait with a timeout.
module ctrl_sequencer #(
  parameter int unsigned OPWIDTH     = 3,
  parameter int unsigned MCODEBITS   = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 instr_valid,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 mem_ready,
  output logic                 instr_ready,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 done,
  output logic                 halted,
  output logic                 err
);

  localparam int unsigned CNTW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MEM_TIMEOUT - 1);
  localparam logic [OPWIDTH-1:0] ALU_PASS = '1;

  localparam logic [2:0] OP_LOAD   = 3'b000;
  localparam logic [2:0] OP_STORE  = 3'b001;
  localparam logic [2:0] OP_ROTATE = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t               state;
  logic [MCODEBITS-1:0] instr_q;
  logic [CNTW-1:0]      wait_cnt;
  logic                 is_load;
  logic                 is_store;

  logic [2:0]           op_in;
  logic [2:0]           op_q;
  logic                 dec_alusrc;
  logic                 dec_memtoreg;
  logic                 dec_branch;
  logic                 dec_load;
  logic                 dec_store;
  logic [OPWIDTH-1:0]   dec_aluop;

  // Writes are always in place, so the destination select never moves.
  assign RegDst = 1'b0;

  assign op_in = instr[MCODEBITS-1 -: 3];
  assign op_q  = instr_q[MCODEBITS-1 -: 3];

  // Decode the opcode being offered so the word can be registered on accept.
  always_comb begin
    dec_alusrc   = 1'b0;
    dec_memtoreg = 1'b0;
    dec_branch   = 1'b0;
    dec_load     = 1'b0;
    dec_store    = 1'b0;
    dec_aluop    = OPWIDTH'(op_in);
    case (op_in)
      OP_LOAD: begin
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
        dec_load     = 1'b1;
        dec_aluop    = ALU_PASS;
      end
      OP_STORE: begin
        dec_alusrc = 1'b1;
        dec_store  = 1'b1;
        dec_aluop  = ALU_PASS;
      end
      OP_ROTATE: dec_alusrc = 1'b1;
      OP_BRANCH: dec_branch = 1'b1;
      default: ;
    endcase
  end

  // Sequencer FSM with registered control word, strobes and status.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      wait_cnt    <= '0;
      is_load     <= 1'b0;
      is_store    <= 1'b0;
      instr_ready <= 1'b0;
      Branch      <= 1'b0;
      MemtoReg    <= 1'b0;
      MemWrite    <= 1'b0;
      MemRead     <= 1'b0;
      ALUSrc      <= 1'b0;
      RegWrite    <= 1'b0;
      ALUOp       <= ALU_PASS;
      done        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      done     <= 1'b0;
      RegWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            // Word is registered here so it is already valid throughout DECODE.
            instr_q     <= instr;
            instr_ready <= 1'b0;
            ALUSrc      <= dec_alusrc;
            MemtoReg    <= dec_memtoreg;
            Branch      <= dec_branch;
            ALUOp       <= dec_aluop;
            is_load     <= dec_load;
            is_store    <= dec_store;
            state       <= S_DECODE;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          if (op_q == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            // Branch retires in EXEC, so its done pulse lines up with EXEC.
            done  <= (op_q == OP_BRANCH);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) begin
            MemRead  <= is_load;
            MemWrite <= is_store;
            wait_cnt <= '0;
            state    <= S_MEM;
          end else if (Branch) begin
            instr_ready <= 1'b1;
            Branch      <= 1'b0;
            ALUOp       <= ALU_PASS;
            ALUSrc      <= 1'b0;
            MemtoReg    <= 1'b0;
            state       <= S_IDLE;
          end else begin
            RegWrite <= 1'b1;
            done     <= 1'b1;
            state    <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            done     <= 1'b1;
            if (is_load) begin
              RegWrite <= 1'b1;
              state    <= S_WB;
            end else begin
              instr_ready <= 1'b1;
              is_store    <= 1'b0;
              ALUOp       <= ALU_PASS;
              ALUSrc      <= 1'b0;
              MemtoReg    <= 1'b0;
              state       <= S_IDLE;
            end
          end else if (wait_cnt == CNT_LAST) begin
            wait_cnt <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            err      <= 1'b1;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNTW'(1);
          end
        end
        S_WB: begin
          instr_ready <= 1'b1;
          is_load     <= 1'b0;
          is_store    <= 1'b0;
          Branch      <= 1'b0;
          ALUOp       <= ALU_PASS;
          ALUSrc      <= 1'b0;
          MemtoReg    <= 1'b0;
          state       <= S_IDLE;
        end
        S_HALT: state <= S_HALT;
        S_ERR:  state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer. Output vector layout:
// ready_regdst_branch_memtoreg_memwrite_memread_alusrc_regwrite_aluop_done_halted_err
module tb_ctrl_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       instr_valid;
  logic [2:0] instr;
  logic       mem_ready;
  logic       instr_ready, RegDst, Branch, MemtoReg, MemWrite, MemRead;
  logic       ALUSrc, RegWrite, done, halted, err;
  logic [2:0] ALUOp;
  logic [13:0] outs;

  int errors = 0;
  int checks = 0;

  localparam logic [13:0] V_RESET = 14'b0_0_0_0_0_0_0_0_111_0_0_0;
  localparam logic [13:0] V_IDLE  = 14'b1_0_0_0_0_0_0_0_111_0_0_0;

  ctrl_sequencer #(.OPWIDTH(3), .MCODEBITS(3), .MEM_TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr(instr),
    .mem_ready(mem_ready), .instr_ready(instr_ready), .RegDst(RegDst),
    .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .done(done),
    .halted(halted), .err(err)
  );

  assign outs = {instr_ready, RegDst, Branch, MemtoReg, MemWrite, MemRead,
                 ALUSrc, RegWrite, ALUOp, done, halted, err};

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; instr_valid = 1'b0; instr = 3'b000; mem_ready = 1'b0;
    tick(); tick();
    checks++;
    if (outs !== V_RESET) begin
      errors++; $display("FAIL reset_values: got %b exp %b", outs, V_RESET);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (outs !== V_IDLE) begin
      errors++; $display("FAIL reset_idle_ready: got %b exp %b", outs, V_IDLE);
    end
  endtask

  task automatic test_regreg();
    logic [13:0] exp [$];
    exp.push_back(14'b0_0_0_0_0_0_0_0_010_0_0_0);
    exp.push_back(14'b0_0_0_0_0_0_0_0_010_0_0_0);
    exp.push_back(14'b0_0_0_0_0_0_0_1_010_1_0_0);
    exp.push_back(V_IDLE);
    instr_valid = 1'b1; instr = 3'b010;
    foreach (exp[i]) begin
      tick();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL regreg_t%0d: got %b exp %b", i + 1, outs, exp[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [13:0] exp [$];
    exp.push_back(14'b0_0_0_1_0_0_1_0_111_0_0_0);
    exp.push_back(14'b0_0_0_1_0_0_1_0_111_0_0_0);
    for (int k = 0; k < 3; k++) exp.push_back(14'b0_0_0_1_0_1_1_0_111_0_0_0);
    exp.push_back(14'b0_0_0_1_0_0_1_1_111_1_0_0);
    exp.push_back(V_IDLE);
    instr_valid = 1'b1; instr = 3'b000;
    foreach (exp[i]) begin
      tick();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL load_t%0d: got %b exp %b", i + 1, outs, exp[i]);
      end
      mem_ready = (i == 4);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp [$];
    exp.push_back(14'b0_0_1_0_0_0_0_0_110_0_0_0);
    exp.push_back(14'b0_0_1_0_0_0_0_0_110_1_0_0);
    exp.push_back(V_IDLE);
    exp.push_back(14'b0_0_0_0_0_0_1_0_100_0_0_0);
    exp.push_back(14'b0_0_0_0_0_0_1_0_100_0_0_0);
    exp.push_back(14'b0_0_0_0_0_0_1_1_100_1_0_0);
    exp.push_back(V_IDLE);
    instr_valid = 1'b1; instr = 3'b110;
    foreach (exp[i]) begin
      tick();
      if (i == 0) instr = 3'b100;
      if (i == 3) instr_valid = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL b2b_t%0d: got %b exp %b", i + 1, outs, exp[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [13:0] exp [$];
    exp.push_back(14'b0_0_0_0_0_0_0_0_111_0_0_0);
    for (int k = 0; k < 4; k++) exp.push_back(14'b0_0_0_0_0_0_0_0_111_0_1_0);
    instr_valid = 1'b1; instr = 3'b111;
    foreach (exp[i]) begin
      tick();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL halt_t%0d: got %b exp %b", i + 1, outs, exp[i]);
      end
      if (i == 1) begin instr_valid = 1'b1; instr = 3'b010; end
    end
    instr_valid = 1'b0;
    Reset = 1'b1; #1;
    checks++;
    if (outs !== V_RESET) begin
      errors++; $display("FAIL halt_reset: got %b exp %b", outs, V_RESET);
    end
    tick(); Reset = 1'b0; tick();
    checks++;
    if (outs !== V_IDLE) begin
      errors++; $display("FAIL halt_reset_idle: got %b exp %b", outs, V_IDLE);
    end
  endtask

  task automatic test_reset_mid_mem();
    instr_valid = 1'b1; instr = 3'b000; mem_ready = 1'b0;
    tick(); instr_valid = 1'b0;
    tick(); tick();
    checks++;
    if (outs !== 14'b0_0_0_1_0_1_1_0_111_0_0_0) begin
      errors++; $display("FAIL midmem_in_mem: got %b exp %b", outs, 14'b0_0_0_1_0_1_1_0_111_0_0_0);
    end
    Reset = 1'b1; #1;
    checks++;
    if (outs !== V_RESET) begin
      errors++; $display("FAIL midmem_reset: got %b exp %b", outs, V_RESET);
    end
    tick(); Reset = 1'b0; tick();
    checks++;
    if (outs !== V_IDLE) begin
      errors++; $display("FAIL midmem_idle: got %b exp %b", outs, V_IDLE);
    end
  endtask

  task automatic test_store_timeout();
    logic [13:0] exp [$];
    exp.push_back(14'b0_0_0_0_0_0_1_0_111_0_0_0);
    exp.push_back(14'b0_0_0_0_0_0_1_0_111_0_0_0);
    for (int k = 0; k < 16; k++) exp.push_back(14'b0_0_0_0_1_0_1_0_111_0_0_0);
    for (int k = 0; k < 4; k++) exp.push_back(14'b0_0_0_0_0_0_1_0_111_0_0_1);
    instr_valid = 1'b1; instr = 3'b001; mem_ready = 1'b0;
    foreach (exp[i]) begin
      tick();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL store_to_t%0d: got %b exp %b", i + 1, outs, exp[i]);
      end
      if (i == 18) begin instr_valid = 1'b1; instr = 3'b010; end
    end
    instr_valid = 1'b0;
    Reset = 1'b1; #1;
    checks++;
    if (outs !== V_RESET) begin
      errors++; $display("FAIL store_to_reset: got %b exp %b", outs, V_RESET);
    end
    tick(); Reset = 1'b0; tick();
    checks++;
    if (outs !== V_IDLE) begin
      errors++; $display("FAIL store_to_idle: got %b exp %b", outs, V_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_regreg();
    test_load_wait();
    test_back_to_back();
    test_halt();
    test_reset_mid_mem();
    test_store_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
